// File: rtl/VGA_Timing.sv
// VGA_Timing: shared timing-stream record produced by the VGA timing generator
package vga_timing_pkg;
  typedef struct packed {
    logic valid;
    logic end_of_frame;
    logic end_of_line;
    logic next_line_visible;
  } VGA_Timing;
endpackage

// File: rtl/vga_line_fetch_scheduler_pkg.sv
// vga_line_fetch_scheduler_pkg: shared video constants and the line-fetch FSM state type
package vga_line_fetch_scheduler_pkg;
  localparam int FETCH_WORD_BITS = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} fetch_state_t;
endpackage

// File: rtl/vga_line_fetch_scheduler_burst_counter.sv
// line_fetch_burst_counter: word-within-burst and burst-within-line counters for one line fetch
module line_fetch_burst_counter #(
  parameter int BURST_WORDS = 8,
  parameter int BURSTS = 40,
  parameter int WB = 3,
  parameter int BI = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          word_inc,
  output logic [WB-1:0] word_idx,
  output logic [BI-1:0] burst_idx,
  output logic          last_word,
  output logic          last_burst
);
  assign last_word = word_idx == WB'(BURST_WORDS - 1);
  assign last_burst = burst_idx == BI'(BURSTS - 1);
  // count returned words, rolling into the next burst and back to burst 0 once the line is complete
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      word_idx <= '0;
      burst_idx <= '0;
    end else if (word_inc) begin
      word_idx <= last_word ? '0 : word_idx + 1'b1;
      if (last_word) burst_idx <= last_burst ? '0 : burst_idx + 1'b1;
    end
endmodule

// File: rtl/vga_line_fetch_scheduler.sv
// vga_line_fetch_scheduler: fetches the next visible line into the idle line-buffer bank; VGA_FETCH_LINE_DOUBLING_EN shows each line twice
module vga_line_fetch_scheduler
  import vga_line_fetch_scheduler_pkg::*, vga_timing_pkg::*;
#(
  parameter int LINE_WORDS = 320,
  parameter int BURST_WORDS = 8,
`ifdef VGA_FETCH_LINE_DOUBLING_EN
  parameter int LINES = 240,
`else
  parameter int LINES = 480,
`endif
  parameter int ADDR_WIDTH = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  VGA_Timing                    timing_i,
  input  logic                         enable_i,
  input  logic [ADDR_WIDTH-1:0]        fb_base_i,
  output logic                         rd_req_o,
  output logic [ADDR_WIDTH-1:0]        rd_addr_o,
  input  logic                         rd_gnt_i,
  input  logic                         rd_valid_i,
  input  logic [FETCH_WORD_BITS-1:0]   rd_data_i,
  output logic                         lb_we_o,
  output logic [$clog2(LINE_WORDS):0]  lb_waddr_o,
  output logic [FETCH_WORD_BITS-1:0]   lb_wdata_o,
  output logic                         lb_bank_o,
  output logic                         busy_o,
  output logic                         underrun_o
);
  localparam int WI = $clog2(LINE_WORDS);
  localparam int BURSTS = LINE_WORDS / BURST_WORDS;
  localparam int WB = BURST_WORDS > 1 ? $clog2(BURST_WORDS) : 1;
  localparam int BI = BURSTS > 1 ? $clog2(BURSTS) : 1;
  localparam int CW = $clog2(LINES + 1);

  fetch_state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] line_ptr;
  logic [CW-1:0] line_cnt;
  logic pending, next_bank, cur_bank;
  logic [WB-1:0] word_idx;
  logic [BI-1:0] burst_idx;
  logic last_word, last_burst;
  logic frame, trig, act, trig_act, fetch_req, busy, start, word_in, line_done, req_bank;

  assign frame = timing_i.valid && timing_i.end_of_frame;
  assign trig = timing_i.valid && timing_i.end_of_line && timing_i.next_line_visible && !frame;
  assign trig_act = trig && act;
  assign fetch_req = frame || (trig_act && line_cnt < CW'(LINES));
  assign busy = state != IDLE;
  assign start = state == IDLE && enable_i && (fetch_req || pending);
  assign word_in = state == WAIT_DATA && rd_valid_i;
  assign line_done = word_in && last_word && last_burst;
  assign req_bank = frame ? 1'b0 : lb_bank_o;

`ifdef VGA_FETCH_LINE_DOUBLING_EN
  logic parity;
  assign act = parity;
  // scanline parity: only every second visible line flips the bank and fetches
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) parity <= 1'b0;
    else parity <= frame ? 1'b0 : trig ? ~parity : parity;
`else
  assign act = 1'b1;
`endif

  line_fetch_burst_counter #(
    .BURST_WORDS(BURST_WORDS),
    .BURSTS(BURSTS),
    .WB(WB),
    .BI(BI)
  ) u_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .word_inc(word_in),
    .word_idx(word_idx),
    .burst_idx(burst_idx),
    .last_word(last_word),
    .last_burst(last_burst)
  );

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nxt;

  // next state: one burst outstanding at a time, back to ISSUE until the line is complete
  always_comb
    state_nxt = state == IDLE ? (start ? ISSUE : IDLE) :
                state == ISSUE ? (rd_gnt_i ? WAIT_DATA : ISSUE) :
                (word_in && last_word) ? (last_burst ? IDLE : ISSUE) : WAIT_DATA;

  // FSM outputs: request and its address are held for the whole ISSUE state
  always_comb begin
    rd_req_o = state == ISSUE;
    rd_addr_o = state == ISSUE ? line_ptr + ADDR_WIDTH'(burst_idx) * ADDR_WIDTH'(BURST_WORDS) : '0;
    busy_o = busy;
  end

  // line bookkeeping, bank selection, pending request and underrun pulse
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      line_ptr <= '0;
      line_cnt <= '0;
      pending <= 1'b0;
      next_bank <= 1'b0;
      cur_bank <= 1'b0;
      lb_bank_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      line_ptr <= frame ? fb_base_i : line_done ? line_ptr + ADDR_WIDTH'(LINE_WORDS) : line_ptr;
      line_cnt <= frame ? '0 : line_done ? line_cnt + 1'b1 : line_cnt;
      pending <= (fetch_req && busy) || (pending && !frame && !start);
      next_bank <= fetch_req ? req_bank : next_bank;
      cur_bank <= start ? (fetch_req ? req_bank : next_bank) : cur_bank;
      lb_bank_o <= trig_act ? ~lb_bank_o : lb_bank_o;
      underrun_o <= fetch_req && busy;
    end

  // register returned words into the target bank of the line being fetched
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      lb_we_o <= 1'b0;
      lb_waddr_o <= '0;
      lb_wdata_o <= '0;
    end else begin
      lb_we_o <= word_in;
      if (word_in) begin
        lb_waddr_o <= {cur_bank, WI'(burst_idx) * WI'(BURST_WORDS) + WI'(word_idx)};
        lb_wdata_o <= rd_data_i;
      end
    end
endmodule

// File: tb/tb_vga_line_fetch_scheduler.sv
// tb_vga_line_fetch_scheduler: scoreboard bench with a line-level reference model and a randomized memory responder
module tb_vga_line_fetch_scheduler;
  import vga_timing_pkg::*;
  localparam int LW = 16, BW = 8, NL = 4, AW = 24, NB = LW / BW, WI = $clog2(LW);
`ifdef VGA_FETCH_LINE_DOUBLING_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  VGA_Timing timing;
  logic enable, rd_gnt, rd_valid;
  logic [15:0] rd_data;
  logic [AW-1:0] fb_base;
  logic rd_req_o, lb_we_o, lb_bank_o, busy_o, underrun_o;
  logic [AW-1:0] rd_addr_o;
  logic [WI:0] lb_waddr_o;
  logic [15:0] lb_wdata_o;

  always #5 clk = ~clk;

  vga_line_fetch_scheduler #(.LINE_WORDS(LW), .BURST_WORDS(BW), .LINES(NL), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .timing_i(timing), .enable_i(enable), .fb_base_i(fb_base),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_gnt_i(rd_gnt), .rd_valid_i(rd_valid),
    .rd_data_i(rd_data), .lb_we_o(lb_we_o), .lb_waddr_o(lb_waddr_o), .lb_wdata_o(lb_wdata_o),
    .lb_bank_o(lb_bank_o), .busy_o(busy_o), .underrun_o(underrun_o)
  );

  logic [AW-1:0] exp_addr[$];
  logic [WI:0] exp_wr[$];
  logic [15:0] exp_data[$];
  int n_chk = 0, n_fail = 0, under_seen = 0, under_exp = 0, we_seen = 0;
  logic [AW-1:0] base_m = '0;
  int lines_m = 0;
  bit bank_m = 1'b0, parity_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, a, e);
    end
  endtask

  task automatic bad(input string name, input logic [31:0] a);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, a);
  endtask

  // reference model: one fetched line = NB burst addresses and LW writes into bank b
  task automatic push_line(input bit b);
    logic [AW-1:0] a;
    a = base_m + AW'(lines_m * LW);
    for (int k = 0; k < NB; k++) exp_addr.push_back(a + AW'(k * BW));
    for (int i = 0; i < LW; i++) exp_wr.push_back({b, WI'(i)});
    lines_m++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_event(input bit eof, input bit trg);
    timing.valid = 1'b1;
    timing.end_of_frame = eof;
    timing.end_of_line = trg;
    timing.next_line_visible = trg;
    @(negedge clk);
    timing = '0;
  endtask

  task automatic frame_start(input logic [AW-1:0] base, input bit trg, output bit fetch);
    base_m = base;
    lines_m = 0;
    parity_m = 1'b0;
    fetch = enable;
    if (fetch) push_line(1'b0);
    fb_base = base;
    drive_event(1'b1, trg);
    chk("bank_after_frame", lb_bank_o, bank_m);
    chk("req_after_frame", rd_req_o, fetch);
  endtask

  task automatic trigger(input bit busy, output bit fetch);
    bit act;
    act = !DBL || parity_m;
    parity_m = !parity_m;
    fetch = 1'b0;
    if (act) begin
      bank_m = !bank_m;
      if (lines_m < NL) begin
        if (busy) begin
          under_exp++;
          push_line(!bank_m);
        end else if (enable) begin
          push_line(!bank_m);
          fetch = 1'b1;
        end
      end
    end
    drive_event(1'b0, 1'b1);
    chk("lb_bank", lb_bank_o, bank_m);
    if (!busy) chk("req_after_trigger", rd_req_o, fetch);
  endtask

  // memory responder: grant after a random delay, data 3 cycles after grant with random bubbles
  task automatic serve_line(input int max_wait);
    for (int b = 0; b < NB; b++) begin
      int w = 0;
      while (!rd_req_o && w < max_wait) begin
        @(negedge clk);
        w++;
      end
      if (!rd_req_o) begin
        bad("req_timeout", w);
        return;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rd_gnt = 1'b1;
      @(negedge clk);
      rd_gnt = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < BW; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        rd_valid = 1'b1;
        rd_data = 16'($urandom);
        exp_data.push_back(rd_data);
        @(negedge clk);
        rd_valid = 1'b0;
      end
    end
  endtask

  // monitor: compares every new request and every line-buffer write against the scoreboard
  initial begin
    bit req_on = 1'b0;
    logic [AW-1:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst) req_on = 1'b0;
      else begin
        if (rd_req_o && !req_on) begin
          req_on = 1'b1;
          held = rd_addr_o;
          if (exp_addr.size() == 0) bad("rd_addr_unexpected", rd_addr_o);
          else chk("rd_addr", rd_addr_o, exp_addr.pop_front());
        end else if (rd_req_o) chk("rd_addr_hold", rd_addr_o, held);
        else req_on = 1'b0;
        if (lb_we_o) begin
          we_seen++;
          if (exp_wr.size() == 0 || exp_data.size() == 0) bad("lb_we_unexpected", lb_waddr_o);
          else begin
            chk("lb_waddr", lb_waddr_o, exp_wr.pop_front());
            chk("lb_wdata", lb_wdata_o, exp_data.pop_front());
          end
        end
        if (underrun_o) under_seen++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit f;
    int u, we0;
    timing = '0;
    enable = 1'b0;
    rd_gnt = 1'b0;
    rd_valid = 1'b0;
    rd_data = '0;
    fb_base = '0;
    cyc(3);
    chk("rst_rd_req", rd_req_o, 0);
    chk("rst_rd_addr", rd_addr_o, 0);
    chk("rst_lb_we", lb_we_o, 0);
    chk("rst_lb_waddr", lb_waddr_o, 0);
    chk("rst_lb_wdata", lb_wdata_o, 0);
    chk("rst_lb_bank", lb_bank_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_underrun", underrun_o, 0);
    rst = 1'b0;
    enable = 1'b1;
    cyc(2);
    frame_start(24'h001000, 1'b0, f);
    serve_line(20);
    cyc(5);
    chk("busy_after_line0", busy_o, 0);
    chk("we_count_line0", we_seen, LW);
    for (int k = 0; k < 8; k++) begin
      trigger(1'b0, f);
      if (f) serve_line(20);
      cyc(60);
    end
    chk("no_underrun_steady", under_seen, 0);
    frame_start(24'h002000, 1'b1, f);
    serve_line(20);
    cyc(5);
    frame_start(24'h003000, 1'b0, f);
    u = under_exp;
    for (int k = 0; k < 2; k++) if (under_exp == u) trigger(1'b1, f);
    serve_line(20);
    serve_line(3);
    cyc(5);
    chk("underrun_count", under_seen, under_exp);
    chk("underrun_one", under_exp - u, 1);
    enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      trigger(1'b0, f);
      cyc(20);
    end
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      trigger(1'b0, f);
      if (f) serve_line(20);
      cyc(20);
    end
    frame_start(24'hFFFFF8, 1'b0, f);
    serve_line(20);
    cyc(5);
    repeat (2) begin
      frame_start(AW'($urandom), 1'b0, f);
      serve_line(20);
      cyc(5);
      for (int k = 0; k < 2 * NL; k++) begin
        trigger(1'b0, f);
        if (f) serve_line(20);
        cyc($urandom_range(10, 40));
      end
    end
    chk("exp_addr_left", exp_addr.size(), 0);
    chk("exp_wr_left", exp_wr.size(), 0);
    chk("exp_data_left", exp_data.size(), 0);
    chk("underrun_total", under_seen, under_exp);
    frame_start(24'h004000, 1'b0, f);
    rd_gnt = 1'b1;
    @(negedge clk);
    rd_gnt = 1'b0;
    cyc(2);
    for (int i = 0; i < 2; i++) begin
      rd_valid = 1'b1;
      rd_data = 16'($urandom);
      exp_data.push_back(rd_data);
      @(negedge clk);
      rd_valid = 1'b0;
    end
    cyc(2);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd_req", rd_req_o, 0);
    chk("arst_rd_addr", rd_addr_o, 0);
    chk("arst_lb_we", lb_we_o, 0);
    chk("arst_lb_waddr", lb_waddr_o, 0);
    chk("arst_lb_wdata", lb_wdata_o, 0);
    chk("arst_lb_bank", lb_bank_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_underrun", underrun_o, 0);
    exp_addr.delete();
    exp_wr.delete();
    exp_data.delete();
    @(negedge clk);
    rst = 1'b0;
    we0 = we_seen;
    for (int i = 0; i < 4; i++) begin
      rd_valid = 1'b1;
      rd_data = 16'($urandom);
      @(negedge clk);
    end
    rd_valid = 1'b0;
    cyc(3);
    chk("stray_we", we_seen, we0);
    chk("stray_busy", busy_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_line_fetch_scheduler.md
# vga_line_fetch_scheduler

Sequences framebuffer reads for the VGA display path. Consumes the `VGA_Timing` stream from the timing generator, issues burst read requests to the memory arbiter so that the next visible line is fetched into the idle half of a double-banked line buffer, and selects the bank the scan-out reads. Sits between the timing generator, the SDRAM/memory arbiter read port and the line buffer RAM.

## Interface
- `LINE_WORDS`, 320: 16-bit words per fetched line; must be a multiple of `BURST_WORDS`.
- `BURST_WORDS`, 8: words per read request.
- `LINES`, 480: fetched lines per frame (240 with line doubling).
- `ADDR_WIDTH`, 24: word address width.
- `clk_i` in 1: the one clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `timing_i` in `VGA_Timing`: timing stream; fields sampled only when `timing_i.valid`.
- `enable_i` in 1: fetching allowed.
- `fb_base_i` in ADDR_WIDTH: framebuffer base word address; latched at end of frame.
- `rd_req_o` out 1: burst read request.
- `rd_addr_o` out ADDR_WIDTH: burst start address; stable while `rd_req_o` is high.
- `rd_gnt_i` in 1: request accepted in this cycle.
- `rd_valid_i` in 1: one returned data word.
- `rd_data_i` in 16: returned data.
- `lb_we_o` out 1: line buffer write strobe.
- `lb_waddr_o` out $clog2(LINE_WORDS)+1: `{bank, word index}`.
- `lb_wdata_o` out 16: line buffer write data.
- `lb_bank_o` out 1: bank the scan-out displays.
- `busy_o` out 1: a line fetch is in progress.
- `underrun_o` out 1: one-cycle pulse; a line was displayed before its fetch completed.

## Operation
- **States:** IDLE, ISSUE, WAIT_DATA.
- **Frame start event:** `timing_i.valid && end_of_frame`.
  - Latch `fb_base_i` into `line_ptr`.
  - Clear `line_cnt`, the parity bit and the pending flag.
  - Request a fetch of line 0 into bank 0.
- **Trigger event:** `timing_i.valid && end_of_line && next_line_visible`.
  - Toggle `lb_bank_o`.
  - If `line_cnt < LINES`, request a fetch of the next line into bank `~new lb_bank_o`.
- **Fetch request:**
  - If the FSM is IDLE and `enable_i` is high, go to ISSUE.
  - If the FSM is busy, set `pending` and pulse `underrun_o`. The in-flight fetch always completes; `pending` starts the next fetch from IDLE.
- **ISSUE:** `rd_req_o=1`, `rd_addr_o = line_ptr + burst_idx*BURST_WORDS`. Advance to WAIT_DATA on `rd_gnt_i`.
- **WAIT_DATA:** count `rd_valid_i` up to `BURST_WORDS`, then:
  - if more bursts remain in the line, go to ISSUE;
  - otherwise add `LINE_WORDS` to `line_ptr`, increment `line_cnt`, go to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- `rd_valid_i` outside WAIT_DATA is ignored.
- `enable_i` low blocks new fetches only; the current line completes. Requests arriving while disabled are dropped, not queued.
- **Simultaneous frame start and trigger:** frame start wins; the trigger is discarded.

## Timing
- **Reset values:** `rd_req_o=0`, `rd_addr_o=0`, `lb_we_o=0`, `lb_waddr_o=0`, `lb_wdata_o=0`, `lb_bank_o=0`, `busy_o=0`, `underrun_o=0`, state IDLE.
- Reset mid-fetch abandons the fetch. Late `rd_valid_i` words from the abandoned burst are ignored because the FSM is in IDLE.
- Event sampled in cycle N → `lb_bank_o` updated at N+1, `rd_req_o` high at N+1.
- `rd_req_o` and `rd_addr_o` are held until `rd_gnt_i`; the next cycle is in WAIT_DATA with `rd_req_o=0`.
- Only one burst is outstanding at a time.
- `rd_valid_i` at cycle N → `lb_we_o`, `lb_waddr_o`, `lb_wdata_o` registered at N+1.
- `busy_o` is high from ISSUE entry until the cycle after the last word of the line.

## Configuration
- **`VGA_FETCH_LINE_DOUBLING_EN` defined:**
  - A parity bit toggles on each trigger.
  - Only triggers with parity 1 flip `lb_bank_o` and request a fetch, so each fetched line is shown on two scanlines and has a two-line fetch window.
  - Set `LINES`=240.
- **Undefined:** every trigger flips the bank and requests a fetch; the parity logic is absent.

## Structure
- `VGA_Timing` stays in the shared `VGA_Timing.sv` header.
- The FSM state enum and a `FETCH_WORD_BITS` constant go in the shared video package.
- **One sub-module, `line_fetch_burst_counter`:** holds the word-within-burst and burst-within-line counters, with `last_word` and `last_burst` flags.

## Test plan
- **Line 0 prefetch.** Stimulus: `LINE_WORDS=16`, `BURST_WORDS=8`, `fb_base_i=0x1000`, one frame-start event, memory answering 8 words 3 cycles after grant. Required: two requests at 0x1000 and 0x1008; 16 writes to bank 0, indices 0–15; `busy_o` then drops.
- **Steady-state lines.** Stimulus: 3 triggers spaced 100 cycles apart. Required: `lb_bank_o` goes 1, 0, 1; fetches at 0x1010, 0x1020, 0x1030 into banks 0, 1, 0; `underrun_o` stays 0.
- **Underrun.** Stimulus: trigger while the memory withholds `rd_gnt_i`. Required: one `underrun_o` pulse; current fetch completes; pending fetch issues immediately after.
- **Stop at `LINES` and wrap.** Stimulus: `LINES=2`, 4 triggers. Required: no fetch after `line_cnt=2`. Separately, `fb_base_i=0xFFFFF8` with `ADDR_WIDTH=24`: second burst address is 0x000000.
- **Reset mid-fetch.** Stimulus: async `rst_i` pulse during WAIT_DATA, then 4 stray `rd_valid_i`. Required: all outputs return to reset values immediately; no `lb_we_o` pulses.
- **`VGA_FETCH_LINE_DOUBLING_EN`.** Stimulus: 4 triggers. Required: `lb_bank_o` flips on the 2nd and 4th only; 2 line fetches issued.
